// File: rtl/coin_acceptor.sv
// Coin acceptor front end: debounces four active-low coin slots, accumulates credit and loads moneyouter.
// Optional WAIT watchdog with sticky fault output: define COIN_ACCEPTOR_TIMEOUT_EN.
module coin_acceptor #(
  parameter int MAX_MONEY = 200,
  parameter int DEBOUNCE  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] coin_n,
  input  logic       buy,
  input  logic       cancel,
  input  logic       flag,
  output logic [7:0] money,
  output logic       en,
  output logic       move25,
  output logic [3:0] coin_reject,
  output logic       deny,
  output logic       sold,
  output logic       busy
`ifdef COIN_ACCEPTOR_TIMEOUT_EN
  ,
  output logic       fault
`endif
);

  localparam int         CNT_W = $clog2(DEBOUNCE + 1);
  localparam logic [8:0] MAX9  = 9'(MAX_MONEY);
  localparam logic [7:0] PRICE = 8'd25;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ARM, S_WAIT, S_DONE} state_t;

  state_t           r_state;
  logic [3:0]       r_sync1, r_sync2, r_stable, r_pend;
  logic [CNT_W-1:0] r_cnt [4];
  logic [3:0]       w_press;
  logic [3:0]       w_pick;
  logic [8:0]       w_sum;
`ifdef COIN_ACCEPTOR_TIMEOUT_EN
  logic [5:0]       r_wd;
`endif

  function automatic logic [7:0] coin_value(input logic [3:0] onehot);
    case (onehot)
      4'b1000: coin_value = 8'd50;
      4'b0100: coin_value = 8'd20;
      4'b0010: coin_value = 8'd10;
      4'b0001: coin_value = 8'd5;
      default: coin_value = 8'd0;
    endcase
  endfunction

  function automatic logic [3:0] highest(input logic [3:0] p);
    if (p[3])      highest = 4'b1000;
    else if (p[2]) highest = 4'b0100;
    else if (p[1]) highest = 4'b0010;
    else if (p[0]) highest = 4'b0001;
    else           highest = 4'b0000;
  endfunction

  // Synchronizer and per-channel debouncer: the stable level flips after enough agreeing samples
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1  <= 4'hF;
      r_sync2  <= 4'hF;
      r_stable <= 4'hF;
      for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1 <= coin_n;
      r_sync2 <= r_sync1;
      for (int i = 0; i < 4; i++) begin
        if (r_sync2[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_W'(DEBOUNCE)) begin
          r_stable[i] <= r_sync2[i];
          r_cnt[i]    <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_press = '0;
    for (int i = 0; i < 4; i++)
      w_press[i] = !r_sync2[i] && r_stable[i] && (r_cnt[i] == CNT_W'(DEBOUNCE));
  end

  assign w_pick = highest(r_pend);
  assign w_sum  = {1'b0, money} + {1'b0, coin_value(w_pick)};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_pend      <= '0;
      money       <= '0;
      en          <= 1'b0;
      move25      <= 1'b0;
      coin_reject <= '0;
      deny        <= 1'b0;
      sold        <= 1'b0;
      busy        <= 1'b0;
`ifdef COIN_ACCEPTOR_TIMEOUT_EN
      r_wd        <= '0;
      fault       <= 1'b0;
`endif
    end else begin
      en          <= 1'b0;
      deny        <= 1'b0;
      sold        <= 1'b0;
      coin_reject <= '0;
      // A fresh press always lands in pending, even while an older coin is being cleared
      if (r_state != S_IDLE) begin
        coin_reject <= r_pend;
        r_pend      <= w_press;
      end else begin
        r_pend <= (r_pend & ~w_pick) | w_press;
      end

      case (r_state)
        S_IDLE: begin
          if (r_pend != '0) begin
            if (w_sum <= MAX9) money <= w_sum[7:0];
            else               coin_reject <= w_pick;
          end else if (cancel && money != '0) begin
            r_state <= S_LOAD;
            move25  <= 1'b0;
            en      <= 1'b1;
            busy    <= 1'b1;
          end else if (buy) begin
            if (money >= PRICE) begin
              r_state <= S_LOAD;
              move25  <= 1'b1;
              en      <= 1'b1;
              busy    <= 1'b1;
            end else begin
              deny <= 1'b1;
            end
          end
        end
        S_LOAD: r_state <= S_ARM;
        S_ARM: begin
          r_state <= S_WAIT;
`ifdef COIN_ACCEPTOR_TIMEOUT_EN
          r_wd    <= '0;
`endif
        end
        S_WAIT: begin
          if (!flag) begin
            r_state <= S_DONE;
`ifdef COIN_ACCEPTOR_TIMEOUT_EN
          end else if (r_wd == 6'd63) begin
            r_state <= S_DONE;
            move25  <= 1'b0;
            fault   <= 1'b1;
          end else begin
            r_wd <= r_wd + 6'd1;
`endif
          end
        end
        S_DONE: begin
          money   <= '0;
          sold    <= move25;
          move25  <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_coin_acceptor.sv
// Self-checking bench for coin_acceptor: directed scenarios followed by a randomized session
// checked against a credit/transaction model of the vending rules.
module tb_coin_acceptor;
  localparam int D   = 4;
  localparam int MAX = 200;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] coin_n = 4'hF;
  logic       buy = 1'b0, cancel = 1'b0, flag = 1'b0;
  logic [7:0] money;
  logic       en, move25, deny, sold, busy;
  logic [3:0] coin_reject;
`ifdef COIN_ACCEPTOR_TIMEOUT_EN
  logic       fault;
`endif

  coin_acceptor #(.MAX_MONEY(MAX), .DEBOUNCE(D)) dut (
    .clk(clk), .rst(rst), .coin_n(coin_n), .buy(buy), .cancel(cancel), .flag(flag),
    .money(money), .en(en), .move25(move25), .coin_reject(coin_reject),
    .deny(deny), .sold(sold), .busy(busy)
`ifdef COIN_ACCEPTOR_TIMEOUT_EN
    , .fault(fault)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_err = 0;
  int n_en, n_deny, n_sold, n_busy;
  int n_rej [4];
  int m_money;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clr_cnt();
    n_en = 0; n_deny = 0; n_sold = 0; n_busy = 0;
    for (int i = 0; i < 4; i++) n_rej[i] = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (en)   n_en++;
    if (deny) n_deny++;
    if (sold) n_sold++;
    if (busy) n_busy++;
    for (int i = 0; i < 4; i++) if (coin_reject[i]) n_rej[i]++;
  endtask

  task automatic do_reset();
    rst = 1'b1; buy = 1'b0; cancel = 1'b0; flag = 1'b0; coin_n = 4'hF;
    repeat (2) tick();
    rst = 1'b0;
    m_money = 0;
    clr_cnt();
  endtask

  task automatic insert(input int idx);
    coin_n[idx] = 1'b0;
    repeat (D + 4) tick();
    coin_n[idx] = 1'b1;
    repeat (D + 5) tick();
  endtask

  task automatic wait_idle(input string tag);
    for (int k = 0; k < 120; k++) begin
      if (!busy) break;
      tick();
    end
    chk(tag, busy, 0);
  endtask

  // Issue a request; a flag_len > 0 emulates moneyouter raising flag after the load strobe
  task automatic request(input logic b, input logic c, input int flag_len);
    buy = b; cancel = c;
    tick();
    buy = 1'b0; cancel = 1'b0;
    if (en && flag_len > 0) begin
      flag = 1'b1;
      repeat (flag_len) tick();
      flag = 1'b0;
    end
    wait_idle("req_idle");
  endtask

  function automatic int value_of(input int idx);
    case (idx)
      3: value_of = 50;
      2: value_of = 20;
      1: value_of = 10;
      default: value_of = 5;
    endcase
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int idx, act, fl, exp_rej;
    // Reset values
    do_reset();
    rst = 1'b1; tick();
    chk("rst_money", money, 0);
    chk("rst_en", en, 0);
    chk("rst_move25", move25, 0);
    chk("rst_reject", coin_reject, 0);
    chk("rst_deny", deny, 0);
    chk("rst_sold", sold, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;

    // Coin latency and no repeat credit while held
    clr_cnt();
    coin_n[1] = 1'b0;
    repeat (D + 3) tick();
    chk("lat_before", money, 0);
    tick();
    chk("lat_at", money, 10);
    repeat (10) tick();
    coin_n[1] = 1'b1;
    repeat (D + 6) tick();
    chk("no_double", money, 10);

    // Ceiling
    do_reset();
    repeat (4) insert(3);
    chk("ceil_200", money, 200);
    insert(0);
    chk("ceil_rej", n_rej[0], 1);
    chk("ceil_hold", money, 200);

    // Simultaneous 50 and 5
    do_reset();
    coin_n = 4'b0110;
    repeat (D + 4) tick();
    chk("sim_50", money, 50);
    tick();
    chk("sim_55", money, 55);
    coin_n = 4'hF;
    repeat (D + 6) tick();
    chk("sim_norej", n_rej[0] + n_rej[3], 0);

    // Deny below price, then a buy with flag high three cycles
    do_reset();
    insert(2);
    request(1'b1, 1'b0, 0);
    chk("deny_pulse", n_deny, 1);
    chk("deny_noen", n_en, 0);
    insert(1);
    chk("money_30", money, 30);
    clr_cnt();
    buy = 1'b1;
    tick();
    buy = 1'b0;
    chk("buy_en", en, 1);
    chk("buy_money", money, 30);
    chk("buy_move25", move25, 1);
    flag = 1'b1;
    repeat (3) tick();
    chk("buy_hold", money, 30);
    flag = 1'b0;
    wait_idle("buy_idle");
    chk("buy_en1", n_en, 1);
    chk("buy_sold", n_sold, 1);
    chk("buy_clear", money, 0);

    // Minimum transaction busy length
    insert(3);
    clr_cnt();
    request(1'b1, 1'b0, 0);
    chk("min_busy", n_busy, 4);
    chk("min_sold", n_sold, 1);

    // Cancel wins over buy; a coin during WAIT is rejected
    do_reset();
    insert(2); insert(1); insert(0);
    chk("money_35", money, 35);
    clr_cnt();
    buy = 1'b1; cancel = 1'b1;
    tick();
    buy = 1'b0; cancel = 1'b0;
    chk("cxl_en", en, 1);
    chk("cxl_move25", move25, 0);
    flag = 1'b1;
    coin_n[2] = 1'b0;
    repeat (D + 8) tick();
    coin_n[2] = 1'b1;
    repeat (D + 6) tick();
    flag = 1'b0;
    wait_idle("cxl_idle");
    chk("cxl_rej", n_rej[2], 1);
    chk("cxl_nosold", n_sold, 0);
    chk("cxl_money", money, 0);

    // Reset during WAIT
    insert(3);
    clr_cnt();
    buy = 1'b1; tick(); buy = 1'b0;
    flag = 1'b1;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    chk("mid_money", money, 0);
    chk("mid_busy", busy, 0);
    chk("mid_move25", move25, 0);
    chk("mid_en", en, 0);
    rst = 1'b0;
    clr_cnt();
    repeat (6) tick();
    flag = 1'b0;
    chk("mid_noen", n_en, 0);

`ifdef COIN_ACCEPTOR_TIMEOUT_EN
    do_reset();
    insert(3);
    clr_cnt();
    buy = 1'b1; tick(); buy = 1'b0;
    flag = 1'b1;
    wait_idle("to_idle");
    chk("to_fault", fault, 1);
    chk("to_money", money, 0);
    chk("to_nosold", n_sold, 0);
    flag = 1'b0;
`endif

    // Randomized session against the credit model
    do_reset();
    for (int it = 0; it < 30; it++) begin
      act = $urandom_range(0, 9);
      clr_cnt();
      if (act < 6) begin
        idx = $urandom_range(0, 3);
        exp_rej = (m_money + value_of(idx) > MAX) ? 1 : 0;
        if (exp_rej == 0) m_money += value_of(idx);
        insert(idx);
        chk("rnd_rej", n_rej[idx], exp_rej);
      end else if (act < 8) begin
        fl = $urandom_range(0, 4);
        request(1'b1, 1'b0, fl);
        chk("rnd_buy_en", n_en, (m_money >= 25) ? 1 : 0);
        chk("rnd_buy_sold", n_sold, (m_money >= 25) ? 1 : 0);
        chk("rnd_buy_deny", n_deny, (m_money >= 25) ? 0 : 1);
        if (m_money >= 25) m_money = 0;
      end else begin
        fl = $urandom_range(0, 4);
        request(1'b0, 1'b1, fl);
        chk("rnd_cxl_en", n_en, (m_money > 0) ? 1 : 0);
        chk("rnd_cxl_sold", n_sold, 0);
        m_money = 0;
      end
      chk("rnd_money", money, m_money);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
